// File: rtl/ofdm_pkg.sv
// Shared OFDM definitions used by ofdm_payload_gen, ofdm_symbol_buffer and the IFFT wrapper.
// Contents: default sample width and symbol length, the packed I/Q sample type, a helper that
// derives the packed I/Q word width, and the read-side state type of the symbol buffer.
package ofdm_pkg;

  localparam int unsigned DATA_SIZE_DEFAULT = 16;
  localparam int unsigned N_FFT_DEFAULT     = 256;
  localparam int unsigned IQ_W_DEFAULT      = 2 * DATA_SIZE_DEFAULT;

  // One frequency-domain subcarrier value, I in the upper half of the packed word.
  typedef struct packed {
    logic [DATA_SIZE_DEFAULT-1:0] i;
    logic [DATA_SIZE_DEFAULT-1:0] q;
  } iq_sample_t;

  // Read side of the ping-pong buffer.
  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } rd_state_e;

  // Width of a packed I/Q word for a given component width.
  function automatic int unsigned iq_width(input int unsigned data_size);
    return 2 * data_size;
  endfunction

endpackage

// File: rtl/ofdm_dpram.sv
// Simple dual-port RAM: one write port, one read port, single clock.
// Read data is registered (one cycle latency) and only updates when re_i is high, so the
// read register holds its value while the consumer stalls. Read-before-write on an address
// collision: a same-cycle write to the address being read returns the old contents.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i     read port request
//   rdata_o          registered read data
module ofdm_dpram #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ofdm_symbol_buffer.sv
// Ping-pong frequency-domain symbol buffer between ofdm_payload_gen and the IFFT.
// Samples are written at their bin index into the current write bank; in_last closes the
// symbol and flips banks. Each full bank is streamed out in bin order 0..N_FFT-1 through a
// 1-deep valid/ready output stage, and every location read is zeroed in the same cycle so
// unwritten bins of the next symbol in that bank read back as zero.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_data_en/i/q/index/last  write side from ofdm_payload_gen
//   wayt_recive_data           write bank free (backpressure to upstream)
//   out_valid/ready            output handshake towards the IFFT
//   out_data_i/q/index/last    output beat
//   overflow                   sticky: a sample was presented while the write bank was busy
module ofdm_symbol_buffer
  import ofdm_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEFAULT,
  parameter int unsigned N_FFT     = N_FFT_DEFAULT,
  parameter int unsigned ADDR_W    = $clog2(N_FFT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_data_en,
  input  logic [DATA_SIZE-1:0] in_data_i,
  input  logic [DATA_SIZE-1:0] in_data_q,
  input  logic [ADDR_W-1:0]    in_index,
  input  logic                 in_last,
  output logic                 wayt_recive_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data_i,
  output logic [DATA_SIZE-1:0] out_data_q,
  output logic [ADDR_W-1:0]    out_index,
  output logic                 out_last,
  output logic                 overflow
);

  localparam int unsigned       IqW      = iq_width(DATA_SIZE);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_FFT - 1);

  rd_state_e         state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              overflow_q, overflow_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic              out_bank_q, out_bank_d;

  logic              wr_accept;
  logic              rd_issue;
  logic              out_accept;
  logic              sym_done;
  logic [IqW-1:0]    ram_rdata [2];
  logic [IqW-1:0]    rd_word;

  assign wayt_recive_data = ~full_q[wr_bank_q];
  assign wr_accept        = in_data_en & wayt_recive_data;
  assign out_accept       = out_valid_q & out_ready;
  // Issue a read only when the output register is empty or being emptied this cycle.
  assign rd_issue         = (state_q == StRead) & (~out_valid_q | out_ready);
  assign sym_done         = (state_q == StDrain) & out_accept & out_last_q;

  // Read-side FSM.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    unique case (state_q)
      StIdle: begin
        rd_addr_d = '0;
        if (full_q[rd_bank_q]) begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (rd_issue) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          if (rd_addr_q == LastAddr) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (sym_done) begin
          rd_bank_d = ~rd_bank_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bank ownership. The read-side clear is applied before the write-side set so a bank that
  // is released and refilled in the same cycle ends up full.
  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    overflow_d = overflow_q;
    if (sym_done) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr_accept && in_last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (in_data_en && !wayt_recive_data) begin
      overflow_d = 1'b1;
    end
  end

  // Output stage. Data lives in the RAM read register, which only advances on rd_issue;
  // the index/last/bank tags travel alongside it here.
  always_comb begin
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    out_bank_d  = out_bank_q;
    if (rd_issue) begin
      out_valid_d = 1'b1;
      out_index_d = rd_addr_q;
      out_last_d  = (rd_addr_q == LastAddr);
      out_bank_d  = rd_bank_q;
    end else if (out_accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_bank_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      out_bank_q  <= out_bank_d;
    end
  end

  // One RAM per bank. The write port carries either upstream samples or the zero write-back
  // of the location being read; the two never target the same bank in one cycle because a
  // bank is written only while not full and read only while full.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] waddr;
    logic [IqW-1:0]    wdata;

    always_comb begin
      if (rd_issue && (rd_bank_q == 1'(b))) begin
        we    = 1'b1;
        waddr = rd_addr_q;
        wdata = '0;
      end else begin
        we    = wr_accept && (wr_bank_q == 1'(b));
        waddr = in_index;
        wdata = {in_data_i, in_data_q};
      end
    end

    assign re = rd_issue && (rd_bank_q == 1'(b));

    ofdm_dpram #(
      .Width (IqW),
      .Depth (N_FFT),
      .AddrW (ADDR_W)
    ) u_ram (
      .clk_i   (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .re_i    (re),
      .raddr_i (rd_addr_q),
      .rdata_o (ram_rdata[b])
    );
  end

  // RAM contents are not reset, so gate the data with valid to give zero outputs when idle.
  assign rd_word    = out_valid_q ? ram_rdata[out_bank_q] : '0;
  assign out_data_i = rd_word[IqW-1 -: DATA_SIZE];
  assign out_data_q = rd_word[DATA_SIZE-1:0];
  assign out_valid  = out_valid_q;
  assign out_index  = out_index_q;
  assign out_last   = out_last_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ofdm_symbol_buffer.sv
// Directed bench for ofdm_symbol_buffer: single symbol with zero-filled bins, back-to-back
// symbols, random output stalls, overflow, zero write-back and reset mid-output with flush.
module tb_ofdm_symbol_buffer;

  localparam int DW = 16;
  localparam int NF = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_data_en = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic [DW-1:0] in_data_q = '0;
  logic [AW-1:0] in_index = '0;
  logic          in_last = 1'b0;
  logic          wayt_recive_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data_i;
  logic [DW-1:0] out_data_q;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int waits = 0;

  logic rand_en = 1'b0;
  logic ready_force = 1'b1;

  // Captured output beats and the cycle each was accepted in.
  logic [DW-1:0] cap_i[$];
  logic [DW-1:0] cap_q[$];
  logic [AW-1:0] cap_idx[$];
  logic          cap_last[$];
  int            cap_cyc[$];

  // Expected beats built from the bench's own symbol model.
  logic [DW-1:0] exp_i[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdl_i[NF];
  logic [DW-1:0] mdl_q[NF];

  logic          hold_pend = 1'b0;
  logic [40:0]   hold_val = '0;

  ofdm_symbol_buffer #(
    .DATA_SIZE (DW),
    .N_FFT     (NF),
    .ADDR_W    (AW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_data_en       (in_data_en),
    .in_data_i        (in_data_i),
    .in_data_q        (in_data_q),
    .in_index         (in_index),
    .in_last          (in_last),
    .wayt_recive_data (wayt_recive_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data_i       (out_data_i),
    .out_data_q       (out_data_q),
    .out_index        (out_index),
    .out_last         (out_last),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    out_ready = rand_en ? ($urandom_range(0, 1) == 1) : ready_force;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Beat capture and stall-stability check, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("stall_hold", {1'b0, out_valid, out_data_i, out_data_q, out_index, out_last},
              {1'b0, 1'b1, hold_val});
      end
      if (out_valid && out_ready) begin
        cap_i.push_back(out_data_i);
        cap_q.push_back(out_data_q);
        cap_idx.push_back(out_index);
        cap_last.push_back(out_last);
        cap_cyc.push_back(cyc);
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_data_i, out_data_q, out_index, out_last};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    cap_i.delete();
    cap_q.delete();
    cap_idx.delete();
    cap_last.delete();
    cap_cyc.delete();
    exp_i.delete();
    exp_q.delete();
  endtask

  // Present one sample once the write bank is free; update the model on acceptance.
  task automatic push(input int idx, input logic [DW-1:0] vi, input logic [DW-1:0] vq,
                      input logic last);
    int budget = 2000;
    while (!wayt_recive_data && budget > 0) begin
      tick();
      budget--;
      waits++;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $error("FAIL push_timeout: wayt_recive_data stuck at 0, bin %0d", idx);
    end
    in_data_en = 1'b1;
    in_index   = idx[AW-1:0];
    in_data_i  = vi;
    in_data_q  = vq;
    in_last    = last;
    tick();
    in_data_en = 1'b0;
    in_last    = 1'b0;
    mdl_i[idx] = vi;
    mdl_q[idx] = vq;
    if (last) begin
      for (int b = 0; b < NF; b++) begin
        exp_i.push_back(mdl_i[b]);
        exp_q.push_back(mdl_q[b]);
        mdl_i[b] = '0;
        mdl_q[b] = '0;
      end
    end
  endtask

  task automatic push_full(input int s);
    for (int b = 0; b < NF; b++) begin
      logic [DW-1:0] bb;
      logic [DW-1:0] ss;
      bb = DW'(b);
      ss = DW'(s);
      push(b, {ss[7:0], bb[7:0]}, ~bb, b == NF - 1);
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    while (cap_i.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    if (cap_i.size() < n) begin
      checks++;
      errors++;
      $error("FAIL beat_timeout: got %0d beats, expected %0d", cap_i.size(), n);
    end
    // Let the final beat be accepted and the bank release complete.
    tick();
    tick();
  endtask

  task automatic compare_all(input string tag);
    int n;
    check({tag, "_count"}, 64'(cap_i.size()), 64'(exp_i.size()));
    n = (cap_i.size() < exp_i.size()) ? cap_i.size() : exp_i.size();
    for (int k = 0; k < n; k++) begin
      check(tag, {23'd0, cap_i[k], cap_q[k], cap_idx[k], cap_last[k]},
            {23'd0, exp_i[k], exp_q[k], AW'(k % NF), (k % NF) == NF - 1});
    end
    clear_all();
  endtask

  initial begin
    for (int b = 0; b < NF; b++) begin
      mdl_i[b] = '0;
      mdl_q[b] = '0;
    end

    // Reset values.
    repeat (3) tick();
    reset = 1'b0;
    check("rst_wayt", 64'(wayt_recive_data), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", {32'd0, out_data_i, out_data_q}, 64'd0);
    check("rst_index", 64'(out_index), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);

    // Single symbol: bins 1..100 and 156..255 written with i=bin, q=-bin.
    for (int b = 1; b < NF; b++) begin
      if (b <= 100 || b >= 156) begin
        logic [DW-1:0] bb;
        bb = DW'(b);
        push(b, bb, -bb, b == NF - 1);
      end
    end
    check("lat_t1", 64'(out_valid), 64'd0);
    tick();
    check("lat_t2", 64'(out_valid), 64'd0);
    tick();
    check("lat_t3_valid", 64'(out_valid), 64'd1);
    check("lat_t3_index", 64'(out_index), 64'd0);
    wait_beats(NF, 1000);
    if (cap_i.size() == NF) begin
      check("s1_bin0", {32'd0, cap_i[0], cap_q[0]}, 64'd0);
      check("s1_bin100_i", 64'(cap_i[100]), 64'd100);
      check("s1_bin100_q", 64'(cap_q[100]), 64'hFF9C);
      check("s1_bin128", {32'd0, cap_i[128], cap_q[128]}, 64'd0);
      check("s1_bin255_q", 64'(cap_q[255]), 64'hFF01);
      check("s1_last254", 64'(cap_last[254]), 64'd0);
      check("s1_last255", 64'(cap_last[255]), 64'd1);
      check("s1_stream", 64'(cap_cyc[255] - cap_cyc[0]), 64'd255);
    end
    compare_all("s1");

    // Back-to-back full symbols with out_ready held high.
    push_full(1);
    waits = 0;
    push_full(2);
    check("b2b_wayt_sym2", 64'(waits), 64'd0);
    waits = 0;
    push_full(3);
    check("b2b_wayt_sym3_waited", 64'(waits > 0), 64'd1);
    wait_beats(3 * NF, 3000);
    for (int k = 1; k < cap_cyc.size(); k++) begin
      check("b2b_gap", 64'(cap_cyc[k] - cap_cyc[k - 1]), (k % NF == 0) ? 64'd3 : 64'd1);
    end
    compare_all("b2b");

    // Same three symbols with random out_ready.
    rand_en = 1'b1;
    push_full(1);
    push_full(2);
    push_full(3);
    wait_beats(3 * NF, 8000);
    rand_en = 1'b0;
    compare_all("rnd");

    // Overflow: fill both banks while the output is stalled, then push one more sample.
    ready_force = 1'b0;
    push(3, 16'h0303, 16'h0404, 1'b1);
    push(4, 16'h0505, 16'h0606, 1'b1);
    check("ovf_wayt_low", 64'(wayt_recive_data), 64'd0);
    check("ovf_before", 64'(overflow), 64'd0);
    in_data_en = 1'b1;
    in_index   = 8'd10;
    in_data_i  = 16'h7777;
    in_data_q  = 16'h7777;
    tick();
    in_data_en = 1'b0;
    check("ovf_set", 64'(overflow), 64'd1);
    ready_force = 1'b1;
    wait_beats(2 * NF, 2000);
    check("ovf_wayt_back", 64'(wayt_recive_data), 64'd1);
    check("ovf_sticky", 64'(overflow), 64'd1);
    compare_all("ovf");

    // Only bin 5 written (twice, last wins) into a bank that previously held full symbols.
    push(5, 16'h1111, 16'h2222, 1'b0);
    push(5, 16'h5555, 16'hAAAA, 1'b1);
    wait_beats(NF, 1000);
    if (cap_i.size() == NF) begin
      check("wb_bin5", {32'd0, cap_i[5], cap_q[5]}, 64'h5555AAAA);
      check("wb_bin3", {32'd0, cap_i[3], cap_q[3]}, 64'd0);
      check("wb_bin200", {32'd0, cap_i[200], cap_q[200]}, 64'd0);
    end
    compare_all("wb");

    // Reset in the middle of streaming a full symbol out of bank 0.
    for (int b = 0; b < NF; b++) begin
      logic [DW-1:0] bb;
      bb = DW'(b);
      push(b, 16'h8000 | bb, bb, b == NF - 1);
    end
    wait_beats(100, 1000);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_wayt", 64'(wayt_recive_data), 64'd1);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    clear_all();
    // Flush symbol into bank 0: unread bins from before the reset are still there.
    push(255, 16'h0000, 16'h0000, 1'b1);
    wait_beats(NF, 1000);
    check("flush_count", 64'(cap_i.size()), 64'(NF));
    if (cap_i.size() == NF) begin
      check("flush_stale200", {32'd0, cap_i[200], cap_q[200]}, 64'h80C800C8);
      check("flush_idx255", 64'(cap_idx[255]), 64'd255);
    end
    clear_all();
    // Both banks now clean.
    push(7, 16'h0707, 16'hF0F0, 1'b1);
    wait_beats(NF, 1000);
    compare_all("post_b1");
    push(9, 16'h0909, 16'h9090, 1'b1);
    wait_beats(NF, 1000);
    compare_all("post_b0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofdm_symbol_buffer.md
# ofdm_symbol_buffer

Ping-pong frequency-domain symbol buffer between `ofdm_payload_gen` and the IFFT. It captures the mapped I/Q subcarrier values produced by `ofdm_payload_gen` at their bin indices, zero-fills every bin that was not written (nulls, DC, guards), and streams each complete symbol to the IFFT in natural bin order 0..N_FFT-1. It also produces `wayt_recive_data` for `ofdm_payload_gen` as backpressure.

## Interface
- `DATA_SIZE`, 16: I/Q sample width in bits, matches `ofdm_payload_gen`.
- `N_FFT`, 256: symbol length in bins; must be a power of two.
- `ADDR_W`, $clog2(N_FFT): bin index width.
- `clk` in 1: single clock; all logic is clocked on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_data_en` in 1: input sample valid.
- `in_data_i`, `in_data_q` in DATA_SIZE: subcarrier value, two's complement.
- `in_index` in ADDR_W: FFT bin index for this sample (low bits of `counter_data`).
- `in_last` in 1: qualifies the final sample of a symbol; closes the symbol.
- `wayt_recive_data` out 1: high means the current write bank is free; upstream may present samples.
- `out_valid` out 1: output sample valid.
- `out_ready` in 1: IFFT accepts sample.
- `out_data_i`, `out_data_q` out DATA_SIZE: bin value, or 0 for unwritten bins.
- `out_index` out ADDR_W: bin number being output.
- `out_last` out 1: high with bin N_FFT-1.
- `overflow` out 1: sticky; sample arrived while `wayt_recive_data` was low.

## Operation
- Two banks, each N_FFT x (2*DATA_SIZE) words, plus per-bank `full` flags. `wr_bank` and `rd_bank` are 1-bit pointers.
- Write side:
  - A sample with `in_data_en` and `wayt_recive_data` high is written to `bank[wr_bank][in_index]`.
  - `in_last` accepted -> set `full[wr_bank]` and toggle `wr_bank`.
  - Duplicate indices within a symbol: the last write wins.
- `wayt_recive_data = !full[wr_bank]`. A sample arriving while it is low is dropped and sets `overflow`. `overflow` is cleared only by `reset`.
- Read FSM:
  - `IDLE`: go to `READ` when `full[rd_bank]`. Read address is cleared to 0.
  - `READ`: issue a RAM read of `rd_addr` whenever the output stage will be empty or accepted that cycle. After each read, write zero back to that location, so the bank is clean for its next fill.
  - Issuing address N_FFT-1 -> go to `DRAIN`.
  - `DRAIN`: wait until the beat with `out_last` is accepted. Then clear `full[rd_bank]`, toggle `rd_bank`, and return to `IDLE`.
- Output stage is a 1-deep register holding data, index and last. It follows valid/ready rules: once `out_valid` is high, it and the data stay stable until `out_ready`.
- No arithmetic on data; values pass bit-exact.

## Timing
- Reset values: `wayt_recive_data`=1, `out_valid`=0, `out_data_i/q`=0, `out_index`=0, `out_last`=0, `overflow`=0. Also `full`=00, `wr_bank`=`rd_bank`=0, FSM=`IDLE`.
- Reset does not clear the RAMs. After a reset mid-symbol, stale bins persist until that bank has been read once. System bring-up requires one flush symbol; the bench checks this explicitly.
- Latency: `in_last` accepted at cycle T -> `full` set at T+1 -> read issued at T+2 -> `out_valid` at T+3 with bin 0.
- With `out_ready` held high, the buffer streams 1 sample/cycle, N_FFT consecutive beats.
- Same-cycle `in_last` into bank B while the read side clears `full[B]`: the clear applies first, then the set, so B ends full.
- Both banks full: `wayt_recive_data` rises the cycle after the read side clears `full`.
- `out_ready` low: read issue pauses and the output register holds. No beat is lost or duplicated.

## Structure
- Shared package `ofdm_pkg`: `N_FFT`, `DATA_SIZE` defaults and the I/Q sample struct/width constant, also used by `ofdm_payload_gen` and the IFFT wrapper.
- Sub-module `ofdm_dpram`: simple dual-port RAM, 1 write + 1 read port, 1-cycle registered read. Instantiated once per bank. The zero write-back uses the write port, muxed with the input path; the banks are disjoint so there is no conflict.

## Test plan
- Single symbol, bins 1..100 and 156..255 written with i=bin, q=-bin, `in_last` on bin 255 -> 256 beats; bins 0 and 101..155 output 0/0; `out_last` only on bin 255.
- Back-to-back symbols with `out_ready`=1 -> `wayt_recive_data` stays high through the second symbol, drops during the third until bank 0 drains; no gap between output symbols except the 2-cycle restart.
- Random `out_ready` (50%) -> output sequence is identical to the `out_ready`=1 run; data held stable while stalled.
- Sample pushed while `wayt_recive_data`=0 -> `overflow`=1, sample absent from output.
- Symbol with only bin 5 written, following a full symbol in the same bank -> every bin except 5 outputs 0, proving the zero write-back.
- `reset` asserted mid-output -> next cycle `out_valid`=0 and `wayt_recive_data`=1; after one flush symbol, output is clean.
